// File: rtl/piano_voice_arbiter.sv
// piano_voice_arbiter
//   Shares one square-wave tone generator between NUM_KEYS light-sensor keys.
//   Each key is synchronised and debounced in a per-key lane. The newest press
//   wins. When the selected key is released, the lowest-index key still held
//   takes over. Every note start or change goes through a silent MUTE gap, so
//   the generator is never retuned while it is sounding.
// Ports
//   clk          system clock
//   rst          asynchronous, active-low reset
//   key_in       raw key levels (1 = pressed), asynchronous to clk
//   half_period  divider load value for the tone generator
//   tone_en      1 = speaker toggles, 0 = speaker held low
//   retune       one-cycle reload strobe, coincident with entering PLAY
//   active_key   index of the selected key
//   keys_held    debounced key states

// Per-key lane: 2-flop synchroniser followed by a mismatch-run debouncer.
module piano_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic held
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          held_q, held_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[0], raw_in};
    held_d = held_q;
    cnt_d  = '0;
    // The count records how many cycles in a row the input has disagreed with
    // the held state. The held state flips on the cycle that completes the run.
    if (sync_q[1] != held_q) begin
      if (cnt_q == CNT_LAST) held_d = ~held_q;
      else                   cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      held_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      held_q <= held_d;
      cnt_q  <= cnt_d;
    end
  end

  assign held = held_q;
endmodule

module piano_voice_arbiter #(
  parameter int NUM_KEYS        = 8,
  parameter int CLK_HZ          = 50000000,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_KEYS-1:0]         key_in,
  output logic [31:0]                 half_period,
  output logic                        tone_en,
  output logic                        retune,
  output logic [$clog2(NUM_KEYS)-1:0] active_key,
  output logic [NUM_KEYS-1:0]         keys_held
);
  localparam int KW = $clog2(NUM_KEYS);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MUTE, PLAY} state_t;

  // Half-period divider value for each key, truncating at each division.
  function automatic logic [31:0] note_hp(input logic [KW-1:0] k);
    logic [31:0] hp;
    case (k)
      3'd0:    hp = 32'(CLK_HZ / 110 / 2);
      3'd1:    hp = 32'(CLK_HZ / 123 / 2);
      3'd2:    hp = 32'(CLK_HZ / 131 / 2);
      3'd3:    hp = 32'(CLK_HZ / 147 / 2);
      3'd4:    hp = 32'(CLK_HZ / 165 / 2);
      3'd5:    hp = 32'(CLK_HZ / 175 / 2);
      3'd6:    hp = 32'(CLK_HZ / 196 / 2);
      default: hp = 32'(CLK_HZ / 220 / 2);
    endcase
    return hp;
  endfunction

  // Lowest set bit index. Returns 0 for an all-zero vector; callers gate on
  // the vector being non-zero first.
  function automatic logic [KW-1:0] lowest(input logic [NUM_KEYS-1:0] v);
    logic [KW-1:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (v[i]) idx = KW'(i);
    return idx;
  endfunction

  logic [NUM_KEYS-1:0] held;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_lane
    piano_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .raw_in (key_in[g]),
      .held   (held[g])
    );
  end

  state_t              state_q, state_d;
  logic [NUM_KEYS-1:0] held_prev_q, held_prev_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [KW-1:0]       active_key_q, active_key_d;
  logic [31:0]         half_period_q, half_period_d;
  logic                tone_en_q, tone_en_d;
  logic                retune_q, retune_d;

  logic [NUM_KEYS-1:0] press;
  logic                any_held;
  logic [KW-1:0]       sel;
  logic                sel_change;

  always_comb begin
    press    = held & ~held_prev_q;
    any_held = |held;
    // A fresh press outranks everything. Otherwise keep the current key while
    // it is held, or fall back to the lowest-index key that is still held.
    if (|press)                  sel = lowest(press);
    else if (held[active_key_q]) sel = active_key_q;
    else                         sel = lowest(held);
    sel_change = (sel != active_key_q);
  end

  always_comb begin
    state_d       = state_q;
    held_prev_d   = held;
    gap_d         = gap_q;
    active_key_d  = active_key_q;
    half_period_d = half_period_q;
    case (state_q)
      IDLE: begin
        if (any_held) begin
          state_d      = MUTE;
          active_key_d = sel;
          gap_d        = '0;
        end
      end
      MUTE: begin
        if (!any_held) begin
          state_d = IDLE;
        end else if (sel_change) begin
          active_key_d = sel;
          gap_d        = '0;
        end else if (gap_q == GAP_LAST) begin
          state_d       = PLAY;
          half_period_d = note_hp(active_key_q);
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      PLAY: begin
        if (!any_held) begin
          state_d = IDLE;
        end else if (sel_change) begin
          state_d      = MUTE;
          active_key_d = sel;
          gap_d        = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    tone_en_d = (state_d == PLAY);
    retune_d  = (state_q == MUTE) && (state_d == PLAY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      held_prev_q   <= '0;
      gap_q         <= '0;
      active_key_q  <= '0;
      half_period_q <= '0;
      tone_en_q     <= 1'b0;
      retune_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      held_prev_q   <= held_prev_d;
      gap_q         <= gap_d;
      active_key_q  <= active_key_d;
      half_period_q <= half_period_d;
      tone_en_q     <= tone_en_d;
      retune_q      <= retune_d;
    end
  end

  assign half_period = half_period_q;
  assign tone_en     = tone_en_q;
  assign retune      = retune_q;
  assign active_key  = active_key_q;
  assign keys_held   = held;
endmodule

// File: tb/tb_piano_voice_arbiter.sv
module tb_piano_voice_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  key_in;
  logic [31:0] half_period;
  logic        tone_en;
  logic        retune;
  logic [2:0]  active_key;
  logic [7:0]  keys_held;

  piano_voice_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .half_period (half_period),
    .tone_en     (tone_en),
    .retune      (retune),
    .active_key  (active_key),
    .keys_held   (keys_held)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    string       tag;
    logic        te;
    logic        rt;
    logic [31:0] hp;
    logic [2:0]  ak;
    logic [7:0]  kh;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push(input int at, input string tag, input logic te, input logic rt,
                      input logic [31:0] hp, input logic [2:0] ak, input logic [7:0] kh);
    exp_t e;
    e.at = at; e.tag = tag; e.te = te; e.rt = rt; e.hp = hp; e.ak = ak; e.kh = kh;
    sb_q.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    n_cmp++;
    assert (tone_en === e.te) else begin
      n_err++; $error("FAIL %s tone_en got %0b exp %0b", e.tag, tone_en, e.te);
    end
    n_cmp++;
    assert (retune === e.rt) else begin
      n_err++; $error("FAIL %s retune got %0b exp %0b", e.tag, retune, e.rt);
    end
    n_cmp++;
    assert (half_period === e.hp) else begin
      n_err++; $error("FAIL %s half_period got %0d exp %0d", e.tag, half_period, e.hp);
    end
    n_cmp++;
    assert (active_key === e.ak) else begin
      n_err++; $error("FAIL %s active_key got %0d exp %0d", e.tag, active_key, e.ak);
    end
    n_cmp++;
    assert (keys_held === e.kh) else begin
      n_err++; $error("FAIL %s keys_held got %02h exp %02h", e.tag, keys_held, e.kh);
    end
  endtask

  // Pop and compare every expectation due at the current edge count.
  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
      e = sb_q.pop_front();
      compare(e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      drain();
    end
  endtask

  int t;

  initial begin
    rst = 1'b0;
    key_in = 8'h00;
    repeat (3) @(negedge clk);
    push(cyc, "reset", 0, 0, 0, 0, 8'h00);
    drain();
    rst = 1'b1;
    step(2);

    // Single key 0: 15-edge start sequence.
    t = cyc; key_in = 8'h01;
    push(t+5,  "k0_prehold", 0, 0, 0, 0, 8'h00);
    push(t+6,  "k0_held",    0, 0, 0, 0, 8'h01);
    push(t+14, "k0_mute",    0, 0, 0, 0, 8'h01);
    push(t+15, "k0_play",    1, 1, 227272, 0, 8'h01);
    push(t+16, "k0_rt_low",  1, 0, 227272, 0, 8'h01);
    step(17);

    // Press key 5 over key 0.
    t = cyc; key_in = 8'h21;
    push(t+6,  "k5_held",    1, 0, 227272, 0, 8'h21);
    push(t+7,  "k5_mute",    0, 0, 227272, 5, 8'h21);
    push(t+14, "k5_gap_end", 0, 0, 227272, 5, 8'h21);
    push(t+15, "k5_play",    1, 1, 142857, 5, 8'h21);
    push(t+16, "k5_rt_low",  1, 0, 142857, 5, 8'h21);
    step(17);

    // Release key 5: fall back to key 0.
    t = cyc; key_in = 8'h01;
    push(t+6,  "r5_held",    1, 0, 142857, 5, 8'h01);
    push(t+7,  "r5_mute",    0, 0, 142857, 0, 8'h01);
    push(t+15, "r5_play",    1, 1, 227272, 0, 8'h01);
    push(t+16, "r5_rt_low",  1, 0, 227272, 0, 8'h01);
    step(17);

    // Release the only key: silence 7 edges later, half_period kept.
    t = cyc; key_in = 8'h00;
    push(t+6,  "r0_held",    1, 0, 227272, 0, 8'h00);
    push(t+7,  "r0_silent",  0, 0, 227272, 0, 8'h00);
    step(10);

    // 3-cycle pulse on key 2 is filtered out.
    t = cyc; key_in = 8'h04;
    push(t+5,  "p3_a",       0, 0, 227272, 0, 8'h00);
    push(t+6,  "p3_b",       0, 0, 227272, 0, 8'h00);
    push(t+8,  "p3_c",       0, 0, 227272, 0, 8'h00);
    step(3);
    key_in = 8'h00;
    step(7);

    // 4-cycle pulse on key 2 reaches keys_held for 4 cycles; MUTE, never PLAY.
    t = cyc; key_in = 8'h04;
    push(t+6,  "p4_held",    0, 0, 227272, 0, 8'h04);
    push(t+7,  "p4_mute",    0, 0, 227272, 2, 8'h04);
    push(t+9,  "p4_still",   0, 0, 227272, 2, 8'h04);
    push(t+10, "p4_clear",   0, 0, 227272, 2, 8'h00);
    push(t+11, "p4_idle",    0, 0, 227272, 2, 8'h00);
    push(t+16, "p4_noplay",  0, 0, 227272, 2, 8'h00);
    step(4);
    key_in = 8'h00;
    step(14);

    // Keys 3 and 6 in the same cycle: lowest index wins.
    t = cyc; key_in = 8'h48;
    push(t+6,  "k36_held",   0, 0, 227272, 2, 8'h48);
    push(t+7,  "k36_mute",   0, 0, 227272, 3, 8'h48);
    push(t+14, "k36_gap",    0, 0, 227272, 3, 8'h48);
    push(t+15, "k36_play",   1, 1, 170068, 3, 8'h48);
    step(17);

    // Releasing non-selected key 6 leaves the tone alone.
    t = cyc; key_in = 8'h08;
    push(t+6,  "r6_held",    1, 0, 170068, 3, 8'h08);
    push(t+7,  "r6_cont",    1, 0, 170068, 3, 8'h08);
    push(t+10, "r6_cont2",   1, 0, 170068, 3, 8'h08);
    step(11);

    // Reset during PLAY silences asynchronously.
    #2 rst = 1'b0;
    #1 push(cyc, "rst_async", 0, 0, 0, 0, 8'h00);
    drain();
    @(negedge clk);
    rst = 1'b1;
    t = cyc;
    push(t+6,  "rr_held",    0, 0, 0, 0, 8'h08);
    push(t+7,  "rr_mute",    0, 0, 0, 3, 8'h08);
    push(t+14, "rr_gap",     0, 0, 0, 3, 8'h08);
    push(t+15, "rr_play",    1, 1, 170068, 3, 8'h08);
    push(t+16, "rr_rt_low",  1, 0, 170068, 3, 8'h08);
    step(17);

    t = cyc; key_in = 8'h00;
    push(t+7,  "end_silent", 0, 0, 170068, 3, 8'h00);
    step(10);

    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL %s never checked: due edge %0d, run ended at edge %0d", e.tag, e.at, cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/piano_voice_arbiter.md
Name: piano_voice_arbiter

Overview:
- Shares one square-wave tone generator (speaker channel) between NUM_KEYS light-sensor piano keys.
- Synchronises and debounces every key, then picks one key by last-pressed priority.
- Drives the generator's half-period divider, enable and a one-cycle retune strobe.
- Inserts a silent gap between notes so that note changes never glitch.

Parameters:
- NUM_KEYS, 8: number of key inputs. Fixed at 8; the note table below has 8 entries.
- CLK_HZ, 50000000: clk frequency in Hz, used by the note table.
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised cycles required before the debounced key state changes. Must be at least 1.
- GAP_CYCLES, 8: cycles of forced silence before every note start or note change. Must be at least 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- key_in  in  8  raw light-sensor levels; 1 = key pressed. Asynchronous to clk.
- half_period  out  32  divider load value for the shared tone generator.
- tone_en  out  1  1 = the generator toggles the speaker; 0 = speaker held low.
- retune  out  1  one-cycle pulse: the generator reloads its counter from half_period.
- active_key  out  3  index of the key currently selected.
- keys_held  out  8  debounced key states.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers clear; FSM goes to IDLE.
  - Outputs: half_period=0, tone_en=0, retune=0, active_key=0, keys_held=0.
  - Reset asserted mid-note silences immediately. Released keys start a fresh debounce.
- Synchroniser: two flops per key. The synchronised value is valid after the 2nd clk edge.
- Debounce, per key:
  - Counter increments each cycle that the synchronised value differs from keys_held[i]; it clears whenever they match.
  - keys_held[i] flips on the edge where the mismatch has lasted DEBOUNCE_CYCLES cycles.
  - A pulse shorter than DEBOUNCE_CYCLES never reaches keys_held.
- Press event: rising edge of keys_held[i].
  - Several press events in the same cycle: the lowest index wins.
  - A press event outranks the currently selected key.
- Release of the selected key:
  - New selection is the lowest-index key still held.
  - If no key is held, the next state is IDLE.
- Release of a non-selected key: no effect on the output.
- Note table: half_period = CLK_HZ/f/2, integer truncation at each division.
  - f = 110, 123, 131, 147, 165, 175, 196, 220 Hz for keys 0..7.
  - Default values: 227272, 203252, 190839, 170068, 151515, 142857, 127551, 113636.
- FSM states:
  - IDLE: tone_en=0. If any key is held, latch the selection into active_key and go to MUTE.
  - MUTE: tone_en=0. The gap counter runs GAP_CYCLES cycles. On the final cycle, load half_period=table[active_key] and go to PLAY; retune=1 on that same edge.
  - PLAY: tone_en=1, retune=0.
    - A selection change (new press, or release of the selected key with another key still held) latches the new active_key and goes to MUTE; the gap counter clears.
    - No key held: go to IDLE.
  - A selection change during MUTE latches the new key and restarts the gap counter.
  - All keys released during MUTE: go to IDLE, no retune.
- Latency (defaults, key_in rises before edge 1, all quiet before):
  - keys_held set at edge 6.
  - MUTE entered at edge 7.
  - PLAY entered at edge 15: tone_en=1, retune=1 for edge 15 only.
- Release latency: tone_en falls on the edge after keys_held clears, which is 2+DEBOUNCE_CYCLES+1 edges after key_in falls.
- half_period and active_key hold their last value in IDLE.

Test Plan:
- Reset, then hold key_in=8'h01 → tone_en and retune rise at edge 15; half_period=227272; active_key=0; retune low at edge 16.
- Holding key 0 in PLAY, press key 5 → MUTE for 8 cycles, then PLAY with half_period=142857 and active_key=5. Release key 5 → MUTE, then PLAY with key 0 and half_period=227272.
- 3-cycle pulse on key_in[2] → keys_held stays 0 and tone_en stays 0. A 4-cycle pulse → keys_held[2] set for 4 cycles and the FSM enters MUTE.
- Keys 3 and 6 pressed in the same cycle → active_key=3, half_period=170068. Release key 6 → no MUTE, tone continuous.
- Release the only held key → tone_en=0 at 7 edges after key_in falls; half_period unchanged.
- Assert rst during PLAY → all outputs 0 asynchronously. Release rst with key held → full 15-edge start sequence repeats.
